// File: rtl/multi_hart_core_proxy.sv
// Multi-hart CPU context proxy: per-hart context/checkpoint, round-robin hart switch, watchdog halt.
// Latency: ireq/dreq/commit combinational from the active context; context update lands 1 cycle later.
// Backpressure: stall freezes every register (bus requests stay driven); rollback overrides stall.
module multi_hart_core_proxy #(
    parameter int                 NUM_HARTS         = 2,
    parameter int                 NUM_STATES        = 16,
    parameter int                 STATE_W           = 5,
    parameter int                 CTX_W             = 256,
    parameter int                 IREQ_W            = 64,
    parameter int                 DREQ_W            = 128,
    parameter int                 COMMIT_STATE      = 1,
    parameter logic [CTX_W-1:0]   CTX_RESET         = '0,
    parameter logic [CTX_W-1:0]   HARDWIRE_MASK     = '0,
    parameter logic [CTX_W-1:0]   COMMIT_CLEAR_MASK = '0,
    parameter int                 QUANTUM           = 4,
    parameter int                 WATCHDOG          = 64
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_STATES*CTX_W-1:0]    out_ctx,
    input  logic [NUM_STATES*IREQ_W-1:0]   out_ireq,
    input  logic [NUM_STATES*DREQ_W-1:0]   out_dreq,
    input  logic                           stall,
    input  logic                           rollback,
    output logic [CTX_W-1:0]               ctx,
    output logic [CTX_W-1:0]               ctx0,
    output logic [IREQ_W-1:0]              ireq,
    output logic [DREQ_W-1:0]              dreq,
    output logic [2:0]                     hart_id,
    output logic [NUM_HARTS-1:0]           halted,
    output logic                           all_halted,
    output logic                           commit
);

    localparam int CNT_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam int WD_W  = (WATCHDOG > 1) ? $clog2(WATCHDOG) : 1;
    localparam logic [STATE_W-1:0] S_UNKNOWN = STATE_W'(NUM_STATES);
    localparam logic [STATE_W-1:0] S_COMMIT  = STATE_W'(COMMIT_STATE);

    logic [CTX_W-1:0]     ctx_q  [NUM_HARTS];
    logic [CTX_W-1:0]     ctx_d  [NUM_HARTS];
    logic [CTX_W-1:0]     ctx0_q [NUM_HARTS];
    logic [CTX_W-1:0]     ctx0_d [NUM_HARTS];
    logic [NUM_HARTS-1:0] halted_q, halted_d;
    logic [2:0]           active_q, active_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;

    logic [CTX_W-1:0]     cur_ctx, cur_ctx0, sel_ctx, new_ctx, wr_val;
    logic [IREQ_W-1:0]    sel_ireq;
    logic [DREQ_W-1:0]    sel_dreq;
    logic [STATE_W-1:0]   cur_state;
    logic                 act_halted, frozen, wr_ctx, wr_ctx0, set_halt, do_switch, found, commit_c;
    int                   cand;

    // Pick out the active hart's context, checkpoint and halt bit.
    always_comb begin
        cur_ctx    = '0;
        cur_ctx0   = '0;
        act_halted = 1'b0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (active_q == 3'(h)) begin
                cur_ctx    = ctx_q[h];
                cur_ctx0   = ctx0_q[h];
                act_halted = halted_q[h];
            end
        end
        cur_state = cur_ctx[STATE_W-1:0];
    end

    // Select the per-state candidate slot; states outside the legal range select nothing.
    always_comb begin
        sel_ctx  = '0;
        sel_ireq = '0;
        sel_dreq = '0;
        for (int s = 0; s < NUM_STATES; s++) begin
            if (cur_state == STATE_W'(s)) begin
                sel_ctx  = out_ctx[s*CTX_W +: CTX_W];
                sel_ireq = out_ireq[s*IREQ_W +: IREQ_W];
                sel_dreq = out_dreq[s*DREQ_W +: DREQ_W];
            end
        end
    end

    // Sanitise the candidate: hardwired bits, illegal state clamp, commit-scoped scratch clear.
    always_comb begin
        new_ctx = (sel_ctx & ~HARDWIRE_MASK) | (CTX_RESET & HARDWIRE_MASK);
        if (new_ctx[STATE_W-1:0] >= S_UNKNOWN) begin
            new_ctx[STATE_W-1:0] = S_UNKNOWN;
        end
        if (cur_state == S_COMMIT) begin
            new_ctx = (new_ctx & ~COMMIT_CLEAR_MASK) | (CTX_RESET & COMMIT_CLEAR_MASK);
        end
    end

    // Prioritised per-cycle action, write-back to the active hart, then round-robin hart selection.
    always_comb begin
        ctx_d     = ctx_q;
        ctx0_d    = ctx0_q;
        halted_d  = halted_q;
        active_d  = active_q;
        cnt_d     = cnt_q;
        wdog_d    = wdog_q;
        wr_ctx    = 1'b0;
        wr_ctx0   = 1'b0;
        wr_val    = cur_ctx;
        set_halt  = 1'b0;
        do_switch = 1'b0;
        found     = 1'b0;
        commit_c  = 1'b0;
        cand      = 0;
        frozen    = &halted_q;

        if (frozen) begin
            // every hart halted: nothing moves until reset
        end else if (rollback && !act_halted) begin
            wr_ctx = 1'b1;
            wr_val = cur_ctx0;
            wdog_d = '0;
        end else if (stall) begin
            // hold everything
        end else if (cur_state >= S_UNKNOWN) begin
            set_halt  = 1'b1;
            do_switch = 1'b1;
            cnt_d     = '0;
            wdog_d    = '0;
        end else if (wdog_q == WD_W'(WATCHDOG-1)) begin
            wr_ctx = 1'b1;
            wr_val = {cur_ctx[CTX_W-1:STATE_W], S_UNKNOWN};
            wdog_d = '0;
        end else begin
            wr_ctx = 1'b1;
            wr_val = new_ctx;
            if (cur_state == S_COMMIT) begin
                commit_c = 1'b1;
                wr_ctx0  = 1'b1;
                wdog_d   = '0;
                if (cnt_q == CNT_W'(QUANTUM-1)) begin
                    cnt_d     = '0;
                    do_switch = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end

        for (int h = 0; h < NUM_HARTS; h++) begin
            if (active_q == 3'(h)) begin
                if (wr_ctx)   ctx_d[h]    = wr_val;
                if (wr_ctx0)  ctx0_d[h]   = new_ctx;
                if (set_halt) halted_d[h] = 1'b1;
            end
        end

        // Search the other harts in wrap order; with none runnable the pointer stays put.
        for (int k = 1; k < NUM_HARTS; k++) begin
            cand = int'(active_q) + k;
            if (cand >= NUM_HARTS) cand = cand - NUM_HARTS;
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (do_switch && !found && h == cand && !halted_d[h]) begin
                    active_d = 3'(h);
                    found    = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                ctx_q[h]  <= CTX_RESET;
                ctx0_q[h] <= CTX_RESET;
            end
            halted_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            wdog_q   <= '0;
        end else begin
            ctx_q    <= ctx_d;
            ctx0_q   <= ctx0_d;
            halted_q <= halted_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            wdog_q   <= wdog_d;
        end
    end

    assign ctx        = cur_ctx;
    assign ctx0       = cur_ctx0;
    assign ireq       = act_halted ? '0 : sel_ireq;
    assign dreq       = act_halted ? '0 : sel_dreq;
    assign hart_id    = active_q;
    assign halted     = halted_q;
    assign all_halted = &halted_q;
    assign commit     = commit_c & resetn;

endmodule
